// File: rtl/gen_rv_fifo.sv
// Valid/ready FIFO with first-word-fall-through read port, 2^AW entries of DW bits.
// Also reports accepted enqueue/dequeue pulses and the current occupancy.
module gen_rv_fifo #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_data,
  input  logic          flush,
  output logic          push,
  output logic          pop,
  output logic [AW:0]   cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr;
  logic          empty;
  logic          full;

  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign cnt       = wr_ptr - rd_ptr;
  assign deq_data  = mem[rd_ptr[AW-1:0]];

  // Flush suppresses both handshakes so the occupancy counter downstream stays in step.
  assign push = enq_valid & enq_ready & ~flush;
  assign pop  = deq_valid & deq_ready & ~flush;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage has no reset; contents are only observable once a pointer says they are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: tb/tb_gen_rv_fifo.sv
// Self-checking bench for gen_rv_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_gen_rv_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic [DW-1:0] deq_data;
  logic          flush;
  logic          push;
  logic          pop;
  logic [AW:0]   cnt;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_deq;
  logic          last_pop;

  gen_rv_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK(clk), .RSTn(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .flush(flush), .push(push), .pop(pop), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow only from the occupancy of the model queue and the current inputs.
  task automatic check_outputs();
    int n;
    n = q.size();
    chk("enq_ready", 32'(enq_ready), 32'(n < DEPTH));
    chk("deq_valid", 32'(deq_valid), 32'(n > 0));
    chk("cnt", 32'(cnt), 32'(n));
    if (n > 0) chk("deq_data", deq_data, q[0]);
    chk("push", 32'(push), 32'(enq_valid && n < DEPTH && !flush));
    chk("pop", 32'(pop), 32'(deq_ready && n > 0 && !flush));
  endtask

  task automatic step(input logic ev, input logic [DW-1:0] ed, input logic dr, input logic fl);
    logic ep, eq;
    @(negedge clk);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    #1;
    check_outputs();
    ep = ev && q.size() < DEPTH && !fl;
    eq = dr && q.size() > 0 && !fl;
    last_pop = eq;
    if (eq) last_deq = deq_data;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (eq) void'(q.pop_front());
      if (ep) q.push_back(ed);
    end
  endtask

  initial begin
    logic [DW-1:0] prev;
    logic [DW-1:0] d;
    logic          seen_99;

    rst_n = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0; flush = 1'b0;
    last_deq = '0; last_pop = 1'b0;
    #23;
    check_outputs();
    chk("rst_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i * 'h11), 1'b0, 1'b0);
    #1;
    chk("t1_cnt", 32'(cnt), 8);
    chk("t1_enq_ready", 32'(enq_ready), 0);
    chk("t1_deq_data", deq_data, 'h11);

    // 2: full, offer 0x99 while popping
    step(1'b1, 'h99, 1'b1, 1'b0);
    #1;
    chk("t2_cnt", 32'(cnt), 7);
    chk("t2_deq_data", deq_data, 'h22);
    seen_99 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (last_pop && last_deq == 'h99) seen_99 = 1'b1;
    end
    chk("t2_no_99", 32'(seen_99), 0);

    // 3: no bypass when empty
    step(1'b1, 'hA5, 1'b0, 1'b0);
    #1;
    chk("t3_deq_valid", 32'(deq_valid), 1);
    chk("t3_deq_data", deq_data, 'hA5);
    step(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t3_empty", 32'(deq_valid), 0);

    // 4: steady state at cnt=3 across pointer wraps
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(4 + i), 1'b1, 1'b0);
      #1;
      chk("t4_cnt", 32'(cnt), 3);
      chk("t4_order", 32'(last_deq > prev), 1);
      prev = last_deq;
    end

    // 5: flush at cnt=5 overrides handshakes
    step(1'b1, 'h100, 1'b0, 1'b0);
    step(1'b1, 'h101, 1'b0, 1'b0);
    #1;
    chk("t5_cnt_pre", 32'(cnt), 5);
    step(1'b1, 'h102, 1'b1, 1'b1);
    #1;
    chk("t5_cnt", 32'(cnt), 0);
    chk("t5_deq_valid", 32'(deq_valid), 0);

    // 6: asynchronous reset between edges at cnt=4
    for (int i = 0; i < 4; i++) step(1'b1, DW'('h200 + i), 1'b0, 1'b0);
    enq_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cnt", 32'(cnt), 0);
    chk("t6_deq_valid", 32'(deq_valid), 0);
    q.delete();
    #1 rst_n = 1'b1;
    step(1'b1, 'h5A, 1'b0, 1'b0);
    #1;
    chk("t6_after", deq_data, 'h5A);
    chk("t6_after_cnt", 32'(cnt), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      d = $urandom;
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
